// File: rtl/pipe_addsub_if.sv
// Stream bundle for pipe_addsub: operand beat in, result beat out, each with valid/ready.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface pipe_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor, STAGES carry segments behind an operand register.
// Optional signed saturation of the result when PIPE_ADDSUB_SAT_EN is defined.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic           clk,
  input logic           rst_b,
  pipe_addsub_if.slave  bus
);

  localparam int unsigned SEG = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_addsub: STAGES must be at least 1");
  end else if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipe_addsub: WIDTH must be a multiple of STAGES");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("pipe_addsub: WIDTH must be at least 2");
  end

  // Index 0 is the operand register; index k holds the result of carry segment k.
  logic [STAGES:0]  vld_d, vld_q;
  logic [STAGES:0]  cy_d, cy_q;
  logic [WIDTH-1:0] a_d   [STAGES+1];
  logic [WIDTH-1:0] a_q   [STAGES+1];
  logic [WIDTH-1:0] b_d   [STAGES+1];
  logic [WIDTH-1:0] b_q   [STAGES+1];
  logic [WIDTH-1:0] sum_d [STAGES+1];
  logic [WIDTH-1:0] sum_q [STAGES+1];
  logic [SEG:0]     seg_sum;
  logic             en;
  logic             msb_cin;
  logic             ovf;

  // One enable for the whole pipe: it only moves when the output slot is free or draining.
  assign en = ~vld_q[STAGES] | bus.out_ready;

  always_comb begin : next_state
    vld_d   = vld_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    seg_sum = '0;
    if (en) begin
      vld_d[0] = bus.in_valid;
      a_d[0]   = bus.a;
      b_d[0]   = bus.sub ? ~bus.b : bus.b;
      cy_d[0]  = bus.sub ? ~bus.cin : bus.cin;
      sum_d[0] = '0;
      for (int k = 1; k <= int'(STAGES); k++) begin
        seg_sum = {1'b0, a_q[k-1][(k-1)*SEG +: SEG]}
                + {1'b0, b_q[k-1][(k-1)*SEG +: SEG]}
                + {{SEG{1'b0}}, cy_q[k-1]};
        vld_d[k]                      = vld_q[k-1];
        a_d[k]                        = a_q[k-1];
        b_d[k]                        = b_q[k-1];
        sum_d[k]                      = sum_q[k-1];
        sum_d[k][(k-1)*SEG +: SEG]    = seg_sum[SEG-1:0];
        cy_d[k]                       = seg_sum[SEG];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin : state_reg
    if (!rst_b) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      sum_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  // Carry into the MSB recovered from the MSB's own sum bit and its two addend bits.
  assign msb_cin = a_q[STAGES][WIDTH-1] ^ b_q[STAGES][WIDTH-1] ^ sum_q[STAGES][WIDTH-1];
  assign ovf     = msb_cin ^ cy_q[STAGES];

  always_comb begin : outputs
    bus.in_ready  = en;
    bus.out_valid = vld_q[STAGES];
    bus.cout      = cy_q[STAGES];
    bus.ovf       = ovf;
`ifdef PIPE_ADDSUB_SAT_EN
    if (ovf) begin
      bus.s = a_q[STAGES][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      bus.s = sum_q[STAGES];
    end
`else
    bus.s = sum_q[STAGES];
`endif
  end

endmodule
